// File: rtl/id_ex_elastic_reg_if.sv
// ID/EX handshake bundle: decode-side entry with valid/ready, EX-side entry
// with valid/ready, squash control and held-entry count.
interface id_ex_elastic_reg_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned ALU_W  = 3
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [ALU_W-1:0]  alu_sig_in;
    logic              wb_in;
    logic [DATA_W-1:0] r1_in;
    logic [DATA_W-1:0] r2_in;
    logic [RD_W-1:0]   rd_in;
    logic              out_valid;
    logic              out_ready;
    logic [ALU_W-1:0]  alu_sig_out;
    logic              wb_out;
    logic [DATA_W-1:0] r1_out;
    logic [DATA_W-1:0] r2_out;
    logic [RD_W-1:0]   rd_out;
    logic [1:0]        occupancy;

    // Driven by the surrounding pipeline (decode + EX)
    modport master (
        output flush, in_valid, alu_sig_in, wb_in, r1_in, r2_in, rd_in, out_ready,
        input  in_ready, out_valid, alu_sig_out, wb_out, r1_out, r2_out, rd_out, occupancy
    );

    // Implemented by the pipeline register itself
    modport slave (
        input  flush, in_valid, alu_sig_in, wb_in, r1_in, r2_in, rd_in, out_ready,
        output in_ready, out_valid, alu_sig_out, wb_out, r1_out, r2_out, rd_out, occupancy
    );
endinterface

// File: rtl/id_ex_elastic_reg.sv
// Elastic ID/EX pipeline register: main output register plus a one-entry skid
// buffer, valid/ready on both sides, synchronous flush, rd==0 write-back gating.
module id_ex_elastic_reg #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned RD_W         = 5,
    parameter int unsigned ALU_W        = 3,
    parameter bit          ZERO_RD_NOWB = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    id_ex_elastic_reg_if.slave   bus
);

    typedef struct packed {
        logic [ALU_W-1:0]  alu;
        logic              wb;
        logic [DATA_W-1:0] r1;
        logic [DATA_W-1:0] r2;
        logic [RD_W-1:0]   rd;
    } entry_t;

    localparam entry_t ENTRY_ZERO = '0;

    logic   r_main_v;
    logic   r_skid_v;
    logic   r_in_ready;
    logic [1:0] r_occ;
    entry_t r_main;
    entry_t r_skid;

    logic   w_accept;
    logic   w_deliver;
    logic   w_main_v_nxt;
    logic   w_skid_v_nxt;
    entry_t w_main_nxt;
    entry_t w_skid_nxt;
    entry_t w_in_entry;

    // Incoming entry, with write-back suppressed for writes to r0
    always_comb begin
        w_in_entry.alu = bus.alu_sig_in;
        w_in_entry.wb  = bus.wb_in && !(ZERO_RD_NOWB && (bus.rd_in == '0));
        w_in_entry.r1  = bus.r1_in;
        w_in_entry.r2  = bus.r2_in;
        w_in_entry.rd  = bus.rd_in;
    end

    assign w_accept  = bus.in_valid && r_in_ready;
    assign w_deliver = r_main_v && bus.out_ready;

    // Next-state: skid is only ever occupied while main is occupied
    always_comb begin
        w_main_v_nxt = r_main_v;
        w_skid_v_nxt = r_skid_v;
        w_main_nxt   = r_main;
        w_skid_nxt   = r_skid;
        if (bus.flush) begin
            w_main_v_nxt = 1'b0;
            w_skid_v_nxt = 1'b0;
            w_main_nxt   = ENTRY_ZERO;
            w_skid_nxt   = ENTRY_ZERO;
        end else if (!r_main_v) begin
            if (w_accept) begin
                w_main_v_nxt = 1'b1;
                w_main_nxt   = w_in_entry;
            end
        end else if (w_deliver) begin
            if (r_skid_v) begin
                w_main_nxt   = r_skid;
                w_skid_v_nxt = 1'b0;
                w_skid_nxt   = ENTRY_ZERO;
            end else if (w_accept) begin
                w_main_nxt   = w_in_entry;
            end else begin
                w_main_v_nxt = 1'b0;
                w_main_nxt   = ENTRY_ZERO;
            end
        end else if (w_accept) begin
            w_skid_v_nxt = 1'b1;
            w_skid_nxt   = w_in_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_v   <= 1'b0;
            r_skid_v   <= 1'b0;
            r_in_ready <= 1'b1;
            r_occ      <= 2'd0;
            r_main     <= ENTRY_ZERO;
            r_skid     <= ENTRY_ZERO;
        end else begin
            r_main_v   <= w_main_v_nxt;
            r_skid_v   <= w_skid_v_nxt;
            r_in_ready <= !w_skid_v_nxt;
            r_occ      <= 2'({1'b0, w_main_v_nxt}) + 2'({1'b0, w_skid_v_nxt});
            r_main     <= w_main_nxt;
            r_skid     <= w_skid_nxt;
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_main_v;
    assign bus.alu_sig_out = r_main.alu;
    assign bus.wb_out      = r_main.wb;
    assign bus.r1_out      = r_main.r1;
    assign bus.r2_out      = r_main.r2;
    assign bus.rd_out      = r_main.rd;
    assign bus.occupancy   = r_occ;

endmodule
